// File: rtl/primus_pkg.sv
// primus_pkg: types and constants shared by the primus LVDS link blocks.
//   rx_state_e              receiver FSM state encoding
//   LVDS_IDLE_P/LVDS_IDLE_N line levels of an idle (logic 1) differential pair
package primus_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    localparam logic LVDS_IDLE_P = 1'b1;
    localparam logic LVDS_IDLE_N = 1'b0;

endpackage

// File: rtl/primus_sync2.sv
// primus_sync2: two-flop synchroniser for one asynchronous input bit.
//   clk_i   destination clock
//   rst_ni  asynchronous active-low reset; both flops load RST_VAL
//   d_i     asynchronous input
//   q_o     synchronised output
module primus_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/primus_lvds_rx.sv
// primus_lvds_rx: receive side of the primus LVDS serial link.
// Frame: start 0, DATA_W data bits LSB first, optional even parity, stop 1.
//   clk_i         clock, all logic on posedge
//   rst_ni        asynchronous active-low reset
//   lvds_pi/ni    differential input legs (asynchronous)
//   data_o        received word, stable while valid_o
//   valid_o       word available in the holding register
//   ready_i       consumer accepts word when valid_o & ready_i
//   parity_err_o  pulse: parity mismatch, word discarded
//   frame_err_o   pulse: stop bit sampled 0, word discarded
//   line_err_o    pulse: invalid differential level at a sample, frame aborted
//   overrun_o     pulse: good frame completed while holding register full
//
// state     | meaning
// RX_IDLE   | line idle, waiting for a valid 0 (start edge)
// RX_START  | counting to start-bit mid-point, confirm start
// RX_DATA   | sampling DATA_W data bits at mid-bit
// RX_PARITY | sampling the even-parity bit
// RX_STOP   | sampling the stop bit, commit or flag error
module primus_lvds_rx
    import primus_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int CLKS_PER_BIT = 8,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              lvds_pi,
    input  logic              lvds_ni,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              parity_err_o,
    output logic              frame_err_o,
    output logic              line_err_o,
    output logic              overrun_o
);

    localparam int CYC_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [CYC_W-1:0] HALF_TC = CYC_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CYC_W-1:0] BIT_TC  = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    logic p_s, n_s;

    primus_sync2 #(.RST_VAL(LVDS_IDLE_P)) u_sync_p (
        .clk_i (clk_i), .rst_ni(rst_ni), .d_i(lvds_pi), .q_o(p_s)
    );
    primus_sync2 #(.RST_VAL(LVDS_IDLE_N)) u_sync_n (
        .clk_i (clk_i), .rst_ni(rst_ni), .d_i(lvds_ni), .q_o(n_s)
    );

    logic rx_bit, rx_zero, rx_bad;
    assign rx_bit  = p_s;
    assign rx_zero = !p_s && n_s;
    assign rx_bad  = (p_s == n_s);

    rx_state_e         state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              lerr_q, lerr_d;
    logic              ovr_q, ovr_d;
    logic              commit;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        commit  = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        lerr_d  = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                if (rx_zero) begin
                    state_d = RX_START;
                    cyc_d   = '0;
                end
            end
            RX_START: begin
                if (cyc_q == HALF_TC) begin
                    cyc_d = '0;
                    idx_d = '0;
                    par_d = 1'b0;
                    if (rx_zero) begin
                        state_d = RX_DATA;
                    end else begin
                        // A valid 1 is a short glitch; an invalid level is a line fault.
                        state_d = RX_IDLE;
                        lerr_d  = rx_bad;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cyc_q == BIT_TC) begin
                    cyc_d = '0;
                    if (rx_bad) begin
                        lerr_d  = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        // LSB first: after DATA_W shifts the first bit sits at bit 0.
                        shift_d = {rx_bit, shift_q[DATA_W-1:1]};
                        par_d   = par_q ^ rx_bit;
                        if (idx_q == LAST_IDX) begin
                            state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            RX_PARITY: begin
                if (cyc_q == BIT_TC) begin
                    cyc_d = '0;
                    if (rx_bad) begin
                        lerr_d  = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        par_d   = par_q ^ rx_bit;
                        state_d = RX_STOP;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cyc_q == BIT_TC) begin
                    cyc_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_bad) begin
                        lerr_d = 1'b1;
                    end else if (!rx_bit) begin
                        ferr_d = 1'b1;
                    end else if ((PARITY_EN != 0) && par_q) begin
                        perr_d = 1'b1;
                    end else begin
                        commit = 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Single-entry holding register; a commit during a handshake reloads it.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (commit && valid_q && !ready_i) begin
            ovr_d = 1'b1;
        end else if (commit) begin
            data_d  = shift_q;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RX_IDLE;
            cyc_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            lerr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            lerr_q  <= lerr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign line_err_o   = lerr_q;
    assign overrun_o    = ovr_q;

endmodule
